// File: rtl/store_queue_pkg.sv
// Shared types for the store queue and its neighbours (dispatch, memory
// arbiter, load reservation stations).
//
// Contents:
//   NUM_ROB_ENTRIES / NUM_ROB_ENTRIES_BITS - reorder buffer size and index width.
//                                            The size is a power of two, so ROB
//                                            index arithmetic wraps naturally.
//   rob_idx_t                              - ROB index type.
//   lsq_entry_t                            - one load/store queue entry as
//                                            produced by dispatch.
package store_queue_pkg;

  localparam int NUM_ROB_ENTRIES      = 16;
  localparam int NUM_ROB_ENTRIES_BITS = $clog2(NUM_ROB_ENTRIES);
  localparam int PREG_BITS            = 6;
  localparam int XLEN                 = 32;

  typedef logic [NUM_ROB_ENTRIES_BITS-1:0] rob_idx_t;

  typedef struct packed {
    logic [PREG_BITS-1:0] ps1_s;            // address base source register
    logic [PREG_BITS-1:0] ps2_s;            // store data source register
    logic [PREG_BITS-1:0] pd_s;             // destination (unused by stores)
    rob_idx_t             rob_num;          // program-order tag
    logic                 store_load_inst;  // 1 = store
    logic [XLEN-1:0]      rvfi_data;        // retirement trace payload
  } lsq_entry_t;

endpackage

// File: rtl/store_queue.sv
// store_queue - in-order circular FIFO of stores between dispatch/rename and
// the memory arbiter.
//
// Dispatch pushes at most one store per cycle in program order. The memory
// arbiter reads the head combinationally and pops it once the D-cache has
// acknowledged the write. Loads ask whether any store older than themselves is
// still pending. A branch mispredict (always raised by a branch committing at
// the ROB head) flushes every entry.
//
// Build option:
//   SQ_FULL_PUSH_POP_EN - when defined, a push is accepted while the queue is
//                         full provided a pop happens in the same cycle; full
//                         then has a combinational path from pop. When
//                         undefined, full depends on registered state only.
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   mispredict           - flush all entries at the next edge (beats push/pop)
//   push, push_entry     - enqueue request and payload from dispatch
//   full                 - a push would be refused this cycle
//   pop                  - dequeue the head (memory arbiter)
//   sq_head              - entry at the head pointer (don't care when empty)
//   sq_empty             - no valid entries
//   count                - occupancy, 0..DEPTH
//   rob_head             - current ROB head index (age origin)
//   query_rob_num        - ROB index of the load being checked
//   older_store_pending  - a valid store is older than query_rob_num
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mispredict,
  input  logic                            push,
  input  lsq_entry_t                      push_entry,
  output logic                            full,
  input  logic                            pop,
  output lsq_entry_t                      sq_head,
  output logic                            sq_empty,
  output logic [PTR_BITS:0]               count,
  input  logic [NUM_ROB_ENTRIES_BITS-1:0] rob_head,
  input  logic [NUM_ROB_ENTRIES_BITS-1:0] query_rob_num,
  output logic                            older_store_pending
);

  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  lsq_entry_t           mem [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic [PTR_BITS-1:0]  head;
  logic [PTR_BITS-1:0]  tail;
  logic                 do_push;
  logic                 do_pop;
  rob_idx_t             query_age;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign sq_empty = (count == '0);
  assign sq_head  = mem[head];

`ifdef SQ_FULL_PUSH_POP_EN
  // A same-cycle pop frees the head slot, which the push then reuses.
  assign full = (count == FULL_COUNT) && !pop;
`else
  assign full = (count == FULL_COUNT);
`endif

  assign do_push = push && !full;
  assign do_pop  = pop && !sq_empty;

  // ---------------------------------------------------------------------------
  // Pointers, valid bits, occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values; this also makes the ordering below
  // meaningful when pop and push address the same slot.
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      // Placed after the pop so a push into the slot being freed (full queue
      // with push+pop) leaves that slot valid.
      if (do_push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; the valid bits alone say which
  // slots hold live data, so clearing the storage would only cost area.
  always_ff @(posedge clk) begin
    if (!rst && !mispredict && do_push) begin
      mem[tail] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Age check: distance from the ROB head orders instructions even across the
  // ROB wrap point. The ROB size is a power of two, so the truncated
  // subtraction is the modulo.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    older_store_pending = 1'b0;
    query_age           = rob_idx_t'(query_rob_num - rob_head);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (rob_idx_t'(mem[i].rob_num - rob_head) < query_age)) begin
        older_store_pending = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation-only protocol checks: illegal requests are ignored by the
  // logic above, but the requester is misbehaving and should hear about it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && !mispredict) begin
      assert (!(push && full))
        else $warning("store_queue: push while full ignored");
      assert (!(pop && sq_empty))
        else $warning("store_queue: pop while empty ignored");
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue. A scoreboard queue holds the entries
// the queue should contain, in order; pushes append to it and pops compare
// the DUT head against its front. Works with SQ_FULL_PUSH_POP_EN defined or not.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH    = 8;
  localparam int PTR_BITS = $clog2(DEPTH);

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            mispredict;
  logic                            push;
  lsq_entry_t                      push_entry;
  logic                            full;
  logic                            pop;
  lsq_entry_t                      sq_head;
  logic                            sq_empty;
  logic [PTR_BITS:0]               count;
  logic [NUM_ROB_ENTRIES_BITS-1:0] rob_head;
  logic [NUM_ROB_ENTRIES_BITS-1:0] query_rob_num;
  logic                            older_store_pending;

  int n_assert = 0;
  int n_fail   = 0;

  lsq_entry_t sb [$];
  lsq_entry_t blank;

  store_queue #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mispredict          (mispredict),
    .push                (push),
    .push_entry          (push_entry),
    .full                (full),
    .pop                 (pop),
    .sq_head             (sq_head),
    .sq_empty            (sq_empty),
    .count               (count),
    .rob_head            (rob_head),
    .query_rob_num       (query_rob_num),
    .older_store_pending (older_store_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  function automatic lsq_entry_t mk(input logic [3:0] rob, input int tag);
    lsq_entry_t e;
    e.ps1_s           = tag[5:0];
    e.ps2_s           = 6'(tag + 1);
    e.pd_s            = 6'(tag + 2);
    e.rob_num         = rob;
    e.store_load_inst = 1'b1;
    e.rvfi_data       = 32'hA500_0000 | 32'(tag);
    return e;
  endfunction

  // One clock cycle: drive requests, check pre-edge outputs, clock, update
  // the scoreboard, check post-edge outputs with requests idle.
  task automatic cyc(input bit p, input lsq_entry_t e, input bit q, input bit mp);
    bit model_full;
    push = p; push_entry = e; pop = q; mispredict = mp;
    #1;
`ifdef SQ_FULL_PUSH_POP_EN
    model_full = (sb.size() == DEPTH) && !q;
`else
    model_full = (sb.size() == DEPTH);
`endif
    check("full_pre", 64'(full), 64'(model_full));
    if (q && sb.size() > 0) check("pop_head", 64'(sq_head), 64'(sb[0]));
    @(posedge clk);
    #1;
    if (mp) begin
      sb.delete();
    end else begin
      if (q && sb.size() > 0) void'(sb.pop_front());
      if (p && !model_full) sb.push_back(e);
    end
    push = 1'b0; pop = 1'b0; mispredict = 1'b0;
    #1;
    check("count", 64'(count), 64'(sb.size()));
    check("sq_empty", 64'(sq_empty), 64'(sb.size() == 0));
    check("full_post", 64'(full), 64'(sb.size() == DEPTH));
    if (sb.size() > 0) check("sq_head", 64'(sq_head), 64'(sb[0]));
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1 && sb.size() > 0; k++) cyc(1'b0, blank, 1'b1, 1'b0);
  endtask

  initial begin
    blank = '0;
    rst = 1'b1; mispredict = 1'b0; push = 1'b0; pop = 1'b0;
    push_entry = '0; rob_head = '0; query_rob_num = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(sq_empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_older", 64'(older_store_pending), 64'd0);

    // Three pushes then one pop
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(4'(4 + i), 10 + i), 1'b0, 1'b0);
    check("three_count", 64'(count), 64'd3);
    check("three_head_rob", 64'(sq_head.rob_num), 64'd4);
    cyc(1'b0, blank, 1'b1, 1'b0);
    check("pop_head_rob", 64'(sq_head.rob_num), 64'd5);
    check("pop_count", 64'(count), 64'd2);
    drain();

    // Fill, then interleave pop/push so both pointers wrap through 0
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, mk(4'(i), 20 + i), 1'b0, 1'b0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, blank, 1'b1, 1'b0);
      cyc(1'b1, mk(4'(i + 8), 40 + i), 1'b0, 1'b0);
    end

    // Full queue with push and pop together
    cyc(1'b1, mk(4'd3, 60), 1'b1, 1'b0);
`ifdef SQ_FULL_PUSH_POP_EN
    check("full_pp_count", 64'(count), 64'd8);
`else
    check("full_pp_count", 64'(count), 64'd7);
`endif
    drain();

    // Mispredict beats push and pop
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(4'(i), 70 + i), 1'b0, 1'b0);
    rob_head = 4'd2; query_rob_num = 4'd9;
    cyc(1'b1, mk(4'd5, 75), 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(sq_empty), 64'd1);
    check("flush_older", 64'(older_store_pending), 64'd0);
    cyc(1'b1, mk(4'd6, 76), 1'b0, 1'b0);
    check("post_flush_head", 64'(sq_head.rvfi_data), 64'(32'hA500_0000 | 32'd76));
    check("post_flush_tail", 64'(dut.tail), 64'd1);
    cyc(1'b0, blank, 1'b0, 1'b1);

    // Age check across the ROB wrap
    rob_head = 4'd14;
    cyc(1'b1, mk(4'd15, 80), 1'b0, 1'b0);
    cyc(1'b1, mk(4'd1, 81), 1'b0, 1'b0);
    query_rob_num = 4'd0;  #1;
    check("age_q0", 64'(older_store_pending), 64'd1);
    query_rob_num = 4'd15; #1;
    check("age_q15", 64'(older_store_pending), 64'd0);
    query_rob_num = 4'd1;  #1;
    check("age_q1", 64'(older_store_pending), 64'd1);
    query_rob_num = 4'd14; #1;
    check("age_q14", 64'(older_store_pending), 64'd0);
    cyc(1'b0, blank, 1'b0, 1'b1);
    query_rob_num = 4'd0;  #1;
    check("age_empty", 64'(older_store_pending), 64'd0);

    // count==1 with push and pop together
    cyc(1'b1, mk(4'd2, 90), 1'b0, 1'b0);
    cyc(1'b1, mk(4'd3, 91), 1'b1, 1'b0);
    check("one_pp_count", 64'(count), 64'd1);
    check("one_pp_head", 64'(sq_head.rob_num), 64'd3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
